nios_ii_muldiv: RTL
===================

NIOS_II_MULDIV -- requirements
Module: nios_ii_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits; legal range 8..64, even values only.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), meaning iteration counter width.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, request to begin an operation.
REQ-006 SHALL have port op, input, 3 bits, operation select: 0 MUL, 1 MULXSS, 2 MULXUU, 3 DIV, 4 DIVU; codes 5-7 reserved.
REQ-007 SHALL have port operand_a, input, WIDTH bits, multiplicand or dividend.
REQ-008 SHALL have port operand_b, input, WIDTH bits, multiplier or divisor.
REQ-009 SHALL have port flush, input, 1 bit, abort of the in-flight operation.
REQ-010 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-011 SHALL have port done, output, 1 bit, one-cycle pulse marking a valid result.
REQ-012 SHALL have port result, output, WIDTH bits, operation result.
REQ-013 SHALL have port div_by_zero, output, 1 bit, flag qualified by done.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC, FIX and DONE.
REQ-015 SHALL accept start only in IDLE or DONE, latching op, operand_a and operand_b in that cycle; start in CALC or FIX SHALL be ignored.
REQ-016 SHALL move from accept cycle t to CALC at t+1, stay in CALC for exactly WIDTH cycles, enter FIX at t+WIDTH+1 and DONE at t+WIDTH+2, giving a fixed latency for every op including divide-by-zero.
REQ-017 SHALL hold busy=1 in CALC and FIX, and busy=0 in IDLE and DONE.
REQ-018 SHALL hold done=1 only in DONE, for exactly one cycle, then go to IDLE unless start is accepted in DONE (back-to-back, directly to CALC).
REQ-019 SHALL hold result and div_by_zero stable from DONE until the next accepted start.
REQ-020 MUL SHALL return the low WIDTH bits of a*b; MULXSS the high WIDTH bits of the signed 2W-bit product; MULXUU the high WIDTH bits of the unsigned product.
REQ-021 SHALL compute multiplies by radix-2 shift-add on magnitudes, one bit per CALC cycle, with sign correction applied in FIX.
REQ-022 DIV (signed) and DIVU SHALL compute quotients by restoring division, one bit per CALC cycle; signed quotients truncate toward zero.
REQ-023 Divisor zero SHALL give result all-ones and div_by_zero=1 for both DIV and DIVU.
REQ-024 DIV of the most negative value by -1 SHALL return the most negative value with div_by_zero=0.
REQ-025 A reserved op code SHALL complete with normal latency, result 0 and div_by_zero=0.
REQ-026 flush in CALC or FIX SHALL return the FSM to IDLE on the next edge with no done pulse and result unchanged; flush in IDLE or DONE SHALL have no effect.
REQ-027 If flush and start are both asserted in DONE, flush SHALL be ignored and start accepted.

Reset
REQ-028 reset SHALL immediately force state IDLE, busy=0, done=0, result=0, div_by_zero=0 and clear all internal registers, including mid-operation.
REQ-029 The first start after reset deassertion SHALL be accepted on the first rising edge with reset low.

Structure
REQ-030 The op code constants and the FSM state encoding SHALL live in the shared package nios_ii_pkg.
REQ-031 The iterative datapath (accumulator, shift register, counter) SHALL be a single sub-module nios_ii_muldiv_iter, with the FSM and sign handling in the top.

Verification (WIDTH=32)
REQ-032 MUL 7*6 -> done exactly 34 cycles after accept, result 42.
REQ-033 MULXSS 0xFFFFFFFF*0xFFFFFFFF -> result 0; MULXUU with the same operands -> result 0xFFFFFFFE.
REQ-034 DIV -7/2 -> result 0xFFFFFFFD; DIV 0x80000000/0xFFFFFFFF -> result 0x80000000, div_by_zero=0.
REQ-035 DIVU 100/0 -> result 0xFFFFFFFF, div_by_zero=1, same 34-cycle latency.
REQ-036 flush at cycle 10 of CALC -> IDLE next cycle, no done pulse; a new start then gives a correct result. start issued during busy -> ignored.
REQ-037 reset asserted mid-CALC -> all outputs 0 immediately; a back-to-back start in DONE -> second result correct with no idle cycle.

Source files
------------

// File: rtl/nios_ii_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// small op-classification helpers used by the top level.
package nios_ii_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULXSS = 3'd1;
  localparam logic [2:0] OP_MULXUU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd3;
  localparam logic [2:0] OP_DIVU   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULXSS) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/nios_ii_muldiv_iter.sv
// One-bit-per-cycle datapath: radix-2 shift-add multiply or restoring divide
// on unsigned magnitudes. hi/lo hold product halves or remainder/quotient.
module nios_ii_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] shift_init,
  input  logic [WIDTH-1:0] addend_init,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH:0]   acc_reg;
  logic [WIDTH-1:0] mq_reg;
  logic [WIDTH-1:0] b_reg;
  logic             div_reg;
  logic [CNT_W-1:0] count_reg;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Multiply: conditionally add the multiplicand, then shift {acc,mq} right.
  assign add_sum = {1'b0, acc_reg[WIDTH-1:0]} + (mq_reg[0] ? {1'b0, b_reg} : '0);
  // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
  assign shifted = {acc_reg, mq_reg[WIDTH-1]};
  assign diff    = shifted - {2'b00, b_reg};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      mq_reg    <= '0;
      b_reg     <= '0;
      div_reg   <= 1'b0;
      count_reg <= '0;
    end else if (load) begin
      acc_reg   <= '0;
      mq_reg    <= shift_init;
      b_reg     <= addend_init;
      div_reg   <= div_mode;
      count_reg <= '0;
    end else if (step) begin
      count_reg <= count_reg + 1'b1;
      if (div_reg) begin
        if (!diff[WIDTH+1]) begin
          acc_reg <= diff[WIDTH:0];
          mq_reg  <= {mq_reg[WIDTH-2:0], 1'b1};
        end else begin
          acc_reg <= shifted[WIDTH:0];
          mq_reg  <= {mq_reg[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_reg <= {1'b0, add_sum[WIDTH:1]};
        mq_reg  <= {add_sum[0], mq_reg[WIDTH-1:1]};
      end
    end
  end

  assign hi    = acc_reg[WIDTH-1:0];
  assign lo    = mq_reg;
  assign count = count_reg;

endmodule

// File: rtl/nios_ii_muldiv.sv
// Iterative multiply/divide unit: control FSM, operand sign handling and
// result correction around the shared shift-add / restoring datapath.
module nios_ii_muldiv
  import nios_ii_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  state_t           state;
  logic [2:0]       op_reg;
  logic             a_neg_reg;
  logic             b_neg_reg;
  logic             b_zero_reg;

  logic             accept;
  logic             last_step;
  logic             sgn_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] fix_result;
  logic             fix_dbz;
  logic             neg;

  assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign last_step = (state == ST_CALC) && (count == CNT_W'(WIDTH - 1));
  assign sgn_in    = op_is_signed(op);
  assign a_mag     = (sgn_in && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_mag     = (sgn_in && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // Divide shifts the dividend and subtracts the divisor; multiply shifts
  // the multiplier and adds the multiplicand.
  nios_ii_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clock       (clock),
    .reset       (reset),
    .load        (accept),
    .step        (state == ST_CALC),
    .div_mode    (op_is_div(op)),
    .shift_init  (op_is_div(op) ? a_mag : b_mag),
    .addend_init (op_is_div(op) ? b_mag : a_mag),
    .hi          (hi),
    .lo          (lo),
    .count       (count)
  );

  assign neg = a_neg_reg ^ b_neg_reg;

  always_comb begin
    fix_result = '0;
    fix_dbz    = 1'b0;
    case (op_reg)
      OP_MUL:    fix_result = lo;
      OP_MULXSS: fix_result = neg ? (~hi + {{(WIDTH-1){1'b0}}, (lo == '0)}) : hi;
      OP_MULXUU: fix_result = hi;
      OP_DIV: begin
        fix_result = b_zero_reg ? '1 : (neg ? -lo : lo);
        fix_dbz    = b_zero_reg;
      end
      OP_DIVU: begin
        fix_result = b_zero_reg ? '1 : lo;
        fix_dbz    = b_zero_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      op_reg      <= '0;
      a_neg_reg   <= 1'b0;
      b_neg_reg   <= 1'b0;
      b_zero_reg  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state      <= ST_CALC;
            busy       <= 1'b1;
            op_reg     <= op;
            a_neg_reg  <= sgn_in && operand_a[WIDTH-1];
            b_neg_reg  <= sgn_in && operand_b[WIDTH-1];
            b_zero_reg <= (operand_b == '0);
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (last_step) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy <= 1'b0;
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            state       <= ST_DONE;
            done        <= 1'b1;
            result      <= fix_result;
            div_by_zero <= fix_dbz;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
